// File: rtl/lockin_result_reader.sv
// lockin_result_reader: pairs lock-in phase/quadrature results, buffers the
// pairs in a FIFO and exposes them through a 32-bit Avalon-MM slave
// (read latency 1) with a level interrupt.
module lockin_result_reader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] fase_in,
    input  logic        fase_in_valid,
    input  logic [63:0] cuad_in,
    input  logic        cuad_in_valid,
    input  logic        processing_finished,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        irq
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HAVE_F = 2'd1;
    localparam logic [1:0] S_HAVE_C = 2'd2;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Pairing state
    logic [1:0]  state, nxt_state;
    logic [63:0] held_f, held_c;
    logic [63:0] pair_f, pair_c;
    logic        pair_valid, load_f, load_c, err_evt;

    // FIFO storage and bookkeeping
    logic [63:0]   mem_f [DEPTH];
    logic [63:0]   mem_c [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full;

    // Control / status
    logic        irq_en;
    logic [15:0] threshold;
    logic        overflow, pair_err, done, pf_q;
    logic        ctrl_wr, thresh_wr, flush, clr_sticky;
    logic        push, pop, ovf_evt;
    logic [63:0] head_f, head_c;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign unused_bits = ^avs_writedata[31:16];

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    assign ctrl_wr    = avs_write && (avs_address == 3'd5);
    assign thresh_wr  = avs_write && (avs_address == 3'd6);
    assign flush      = ctrl_wr && avs_writedata[1];
    assign clr_sticky = ctrl_wr && avs_writedata[2];

    // A flush swallows both the incoming samples and any pop in its cycle.
    assign pop     = avs_read && (avs_address == 3'd4) && !empty && !flush;
    assign push    = pair_valid && !flush && (!full || pop);
    assign ovf_evt = pair_valid && !flush && full && !pop;

    assign head_f = mem_f[rd_ptr];
    assign head_c = mem_c[rd_ptr];

    // Pairing decision: what completes, what gets held, what counts as an error
    always_comb begin
        nxt_state  = state;
        pair_valid = 1'b0;
        pair_f     = held_f;
        pair_c     = held_c;
        load_f     = 1'b0;
        load_c     = 1'b0;
        err_evt    = 1'b0;
        if (fase_in_valid && cuad_in_valid) begin
            // Simultaneous arrival always pairs directly; a held sample is lost.
            pair_valid = 1'b1;
            pair_f     = fase_in;
            pair_c     = cuad_in;
            err_evt    = (state != S_IDLE);
            nxt_state  = S_IDLE;
        end else if (fase_in_valid) begin
            case (state)
                S_IDLE: begin
                    load_f    = 1'b1;
                    nxt_state = S_HAVE_F;
                end
                S_HAVE_F: begin
                    load_f  = 1'b1;
                    err_evt = 1'b1;
                end
                S_HAVE_C: begin
                    pair_valid = 1'b1;
                    pair_f     = fase_in;
                    nxt_state  = S_IDLE;
                end
                default: nxt_state = S_IDLE;
            endcase
        end else if (cuad_in_valid) begin
            case (state)
                S_IDLE: begin
                    load_c    = 1'b1;
                    nxt_state = S_HAVE_C;
                end
                S_HAVE_C: begin
                    load_c  = 1'b1;
                    err_evt = 1'b1;
                end
                S_HAVE_F: begin
                    pair_valid = 1'b1;
                    pair_c     = cuad_in;
                    nxt_state  = S_IDLE;
                end
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    // Pairing state and sample holders
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state  <= S_IDLE;
            held_f <= '0;
            held_c <= '0;
        end else begin
            state <= nxt_state;
            if (load_f) held_f <= fase_in;
            if (load_c) held_c <= cuad_in;
        end
    end

    // FIFO storage write; no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem_f[wr_ptr] <= pair_f;
            mem_c[wr_ptr] <= pair_c;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Writable control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en    <= 1'b0;
            threshold <= 16'd1;
        end else begin
            if (ctrl_wr) irq_en <= avs_writedata[0];
            if (thresh_wr)
                threshold <= (avs_writedata[15:0] == 16'd0) ? 16'd1 : avs_writedata[15:0];
        end
    end

    // Sticky status bits; a clear wins over a same-cycle set
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            pair_err <= 1'b0;
            done     <= 1'b0;
            // Track the live level so a finish flag held through reset
            // does not look like a fresh rising edge.
            pf_q     <= processing_finished;
        end else begin
            pf_q <= processing_finished;
            if (clr_sticky) begin
                overflow <= 1'b0;
                pair_err <= 1'b0;
                done     <= 1'b0;
            end else begin
                if (ovf_evt)                           overflow <= 1'b1;
                if (err_evt && !flush)                 pair_err <= 1'b1;
                if (processing_finished && !pf_q)      done     <= 1'b1;
            end
        end
    end

    // Read mux for the addressed word
    always_comb begin
        rd_word = '0;
        case (avs_address)
            3'd0: rd_word = {8'h00, 1'b0, state, done, pair_err, overflow,
                             full, empty, 16'(count)};
            3'd1: rd_word = empty ? 32'd0 : head_f[31:0];
            3'd2: rd_word = empty ? 32'd0 : head_f[63:32];
            3'd3: rd_word = empty ? 32'd0 : head_c[31:0];
            3'd4: rd_word = empty ? 32'd0 : head_c[63:32];
            3'd5: rd_word = {31'd0, irq_en};
            3'd6: rd_word = {16'd0, threshold};
            default: rd_word = '0;
        endcase
    end

    // Registered read response, one cycle after the strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= rd_word;
        end
    end

    // Registered interrupt level
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= ((16'(count) >= threshold) && irq_en) || done;
    end

endmodule

// File: doc/lockin_result_reader.md
Name: lockin_result_reader

Overview:
- Consumer end of the lock-in output streams: phase and quadrature 64-bit results with valids, plus the processing-finished flag.
- Pairs each phase sample with its quadrature sample and buffers the pairs in a FIFO.
- Exposes the buffer to the HPS through a 32-bit Avalon-MM slave with read latency 1.
- Sits between signal_processing and the HPS bridge.

Parameters:
- DEPTH, 64, FIFO depth in phase/quadrature pairs; power of two, 4..1024.
- AW, 6, log2(DEPTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fase_in  in  64  signed phase result.
- fase_in_valid  in  1  one-cycle qualifier for fase_in.
- cuad_in  in  64  signed quadrature result.
- cuad_in_valid  in  1  one-cycle qualifier for cuad_in.
- processing_finished  in  1  level from the lock-in; the sticky done bit sets on its rising edge.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  high one cycle after each accepted read.
- irq  out  1  level interrupt: (count >= threshold and irq_en) or done.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (also applies mid-operation): FIFO emptied, pairing holders cleared, sticky bits cleared, threshold = 1, irq_en = 0, avs_readdata = 0, avs_readdatavalid = 0, irq = 0. Any read in the reset cycle is dropped, with no readdatavalid.
- Pairing state machine (IDLE, HAVE_F, HAVE_C):
  - IDLE + fase valid only -> latch fase, go to HAVE_F.
  - IDLE + cuad valid only -> latch cuad, go to HAVE_C.
  - Both valid in the same cycle, in any state -> pair the incoming two directly; any held sample is discarded and pair_err is set; next state IDLE.
  - HAVE_F + cuad valid -> pair is complete, go to IDLE.
  - HAVE_F + another fase -> overwrite the held fase, set sticky pair_err, stay in HAVE_F.
  - HAVE_C is the mirror of HAVE_F.
- Push: a completed pair is written into the FIFO in the same edge.
  - If the FIFO is full and no pop occurs that cycle, the pair is dropped and sticky overflow is set.
  - Push and pop in the same cycle: both succeed and count is unchanged. This also holds when full.
- count range is 0..DEPTH; it is AW+1 bits wide.
- Register map, by word address:
  - 0 STATUS (read): [15:0] count, [16] empty, [17] full, [18] overflow, [19] pair_err, [20] done, [23:21] pairing state.
  - 1 head fase[31:0].
  - 2 head fase[63:32].
  - 3 head cuad[31:0].
  - 4 head cuad[63:32]. Reading this address pops the head if the FIFO is not empty.
  - 5 CTRL (read/write): [0] irq_en, [1] flush (write-1 pulse), [2] clear sticky bits (write-1 pulse).
  - 6 THRESH (read/write): [15:0]. A write of 0 is stored as 1.
  - 7 reads 0.
- Reads of addresses 1-4 while empty return 0 and do not pop.
- Read timing: the address is sampled on the read cycle. avs_readdata and avs_readdatavalid are registered and appear on the next cycle. Reads are accepted on every cycle, back-to-back.
- Writes to read-only addresses are ignored.
- Flush empties the FIFO and returns pairing to IDLE on the next edge.
  - Inputs arriving in the flush cycle are discarded.
  - A pop requested in the same cycle has no further effect.
- Clear-sticky takes priority over a set event in the same cycle.
- The done bit sets on the rising edge of processing_finished, held until cleared.
- irq is registered, so it follows its condition by one cycle.

Test Plan:
- Pairing and read: fase=0x0000000100000002 at cycle 10, cuad=0xFFFFFFFFFFFFFFFE at cycle 13.
  - Then read STATUS -> count=1, empty=0.
  - Reads of addresses 1,2,3,4 -> 0x2, 0x1, 0xFFFFFFFE, 0xFFFFFFFF, each with readdatavalid one cycle later.
  - Final STATUS -> count=0, empty=1.
- Same-cycle pair: fase and cuad valid together, with values 5 and -5.
  - STATUS count=1, pair_err=0.
  - Reads of address 1 and address 3 -> 5 and 0xFFFFFFFB.
- Pair error: fase, fase, cuad.
  - Exactly one pair stored, holding the second fase; pair_err=1.
  - Write CTRL bit2 -> pair_err=0.
- Overflow: DEPTH=4, push 5 pairs with no reads.
  - count=4, full=1, overflow=1; the head holds pair #1.
  - Then push on the same cycle as a read of address 4 -> count stays 4, no further overflow.
- IRQ and done:
  - THRESH=3, irq_en=1; push 2 pairs -> irq=0; third pair -> irq=1 one cycle after count reaches 3.
  - Pulse processing_finished -> done=1 and irq stays high after the FIFO is drained.
- Reset mid-operation: with count=3 and HAVE_F, assert reset for 1 cycle.
  - STATUS reads count=0, empty=1, state IDLE, all sticky bits 0.
  - A cuad arriving next stores nothing (state goes to HAVE_C).
